// File: rtl/mqueue_rf_pkg.sv
// mqueue_rf_pkg: shared, parameter-independent definitions for the
// multi-channel register-file queue.
//   err_cause_e  : classification of the event that sets the sticky error
//   af_thresh_ok : legality check for the almost-full threshold
package mqueue_rf_pkg;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_PUSH_FULL = 2'd1,
      ERR_POP_EMPTY = 2'd2
   } err_cause_e;

   // A threshold is meaningful only between 1 and the per-channel depth.
   function automatic bit af_thresh_ok(input int af, input int depth);
      return (af >= 1) && (af <= depth);
   endfunction

endpackage

// File: rtl/mqueue_rf_if.sv
// mqueue_rf_if: push/pop/flush request bundle and status returned by
// mqueue_rf.
//   master : drives i_push/i_push_ch/i_push_dat, i_pop/i_pop_ch and i_flush;
//            observes the pop result and per-channel status
//   slave  : the queue itself
interface mqueue_rf_if #(
   parameter int W = 32,
   parameter int C = 4
);
   localparam int CH_W = (C > 1) ? $clog2(C) : 1;

   logic            i_push;
   logic [CH_W-1:0] i_push_ch;
   logic [W-1:0]    i_push_dat;
   logic            i_pop;
   logic [CH_W-1:0] i_pop_ch;
   logic [C-1:0]    i_flush;
   logic            o_pop_vld;
   logic [CH_W-1:0] o_pop_ch;
   logic [W-1:0]    o_pop_dat;
   logic [C-1:0]    o_full_w;
   logic [C-1:0]    o_empty_w;
   logic [C-1:0]    o_afull_w;
   logic            o_err;

   modport master (
      output i_push, i_push_ch, i_push_dat, i_pop, i_pop_ch, i_flush,
      input  o_pop_vld, o_pop_ch, o_pop_dat, o_full_w, o_empty_w, o_afull_w, o_err
   );

   modport slave (
      input  i_push, i_push_ch, i_push_dat, i_pop, i_pop_ch, i_flush,
      output o_pop_vld, o_pop_ch, o_pop_dat, o_full_w, o_empty_w, o_afull_w, o_err
   );
endinterface

// File: rtl/mqueue_rf_ch_cntrl.sv
// mqueue_rf_ch_cntrl: pointer pair and status for one channel of mqueue_rf.
//   i_push/i_pop : requests already decoded to this channel
//   i_flush      : resets both pointers, overriding push/pop
//   o_*_ok       : request accepted this cycle
//   o_*_err      : request rejected because of full/empty (not flush)
//   o_wr_lo/o_rd_lo : pointer bits used as the in-region array offset
//   o_full/o_empty/o_afull : status from current pointers
module mqueue_rf_ch_cntrl #(
   parameter int D         = 4,
   parameter int AF_THRESH = 3
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic                 i_flush,
   output logic                 o_push_ok,
   output logic                 o_pop_ok,
   output logic                 o_push_err,
   output logic                 o_pop_err,
   output logic [$clog2(D)-1:0] o_wr_lo,
   output logic [$clog2(D)-1:0] o_rd_lo,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_afull
);
   localparam int PTR_W = $clog2(D) + 1;

   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, occ;

   // One extra MSB distinguishes full from empty when the offsets match.
   assign o_empty = (wr_q == rd_q);
   assign o_full  = (wr_q[PTR_W-2:0] == rd_q[PTR_W-2:0]) && (wr_q[PTR_W-1] != rd_q[PTR_W-1]);
   assign occ     = wr_q - rd_q;
   assign o_afull = (occ >= PTR_W'(AF_THRESH));

   assign o_push_ok  = i_push && !o_full  && !i_flush;
   assign o_pop_ok   = i_pop  && !o_empty && !i_flush;
   assign o_push_err = i_push &&  o_full  && !i_flush;
   assign o_pop_err  = i_pop  &&  o_empty && !i_flush;

   assign o_wr_lo = wr_q[PTR_W-2:0];
   assign o_rd_lo = rd_q[PTR_W-2:0];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (i_flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (o_push_ok) wr_d = wr_q + 1'b1;
         if (o_pop_ok)  rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
endmodule

// File: rtl/rf.sv
// rf: N x W register file, one synchronous write port and one asynchronous
// read port. Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, combinational from i_raddr
module rf #(
   parameter int W = 32,
   parameter int N = 16
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [$clog2(N)-1:0] i_waddr,
   input  logic [W-1:0]         i_wdata,
   input  logic [$clog2(N)-1:0] i_raddr,
   output logic [W-1:0]         o_rdata
);
   logic [W-1:0] mem_q [N];

   always_ff @(posedge clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/mqueue_rf.sv
// mqueue_rf: C independent FIFOs sharing one N-entry register file, each
// channel owning a fixed D = N/C region. One push and one pop per cycle to
// any channel; pop data is registered (1-cycle latency).
//   clk    : clock
//   arst_n : asynchronous active-low reset
//   q      : request/status bundle (slave side), see mqueue_rf_if
module mqueue_rf
   import mqueue_rf_pkg::*;
#(
   parameter int N         = 16,
   parameter int W         = 32,
   parameter int C         = 4,
   parameter int AF_THRESH = 3
) (
   input  logic      clk,
   input  logic      arst_n,
   mqueue_rf_if.slave q
);
   localparam int D      = N / C;
   localparam int CH_W   = (C > 1) ? $clog2(C) : 1;
   localparam int LO_W   = $clog2(D);
   localparam int ADDR_W = $clog2(N);
   // An illegal threshold is clamped to the channel depth.
   localparam int AF_EFF = af_thresh_ok(AF_THRESH, D) ? AF_THRESH : D;

   logic [C-1:0]            push_ok, pop_ok, push_err, pop_err;
   logic [C-1:0][LO_W-1:0]  wr_lo, rd_lo;
   logic [ADDR_W-1:0]       waddr, raddr;
   logic [W-1:0]            rdata;
   err_cause_e              err_cause;

   logic                    pop_vld_d, pop_vld_q;
   logic [CH_W-1:0]         pop_ch_d,  pop_ch_q;
   logic [W-1:0]            pop_dat_d, pop_dat_q;
   logic                    err_d,     err_q;

   function automatic logic [ADDR_W-1:0] phys_addr(input logic [CH_W-1:0] ch,
                                                   input logic [LO_W-1:0] lo);
      return (ADDR_W'(ch) << LO_W) | ADDR_W'(lo);
   endfunction

   for (genvar g = 0; g < C; g++) begin : g_ch
      mqueue_rf_ch_cntrl #(.D(D), .AF_THRESH(AF_EFF)) u_ch (
         .clk        (clk),
         .arst_n     (arst_n),
         .i_push     (q.i_push && (q.i_push_ch == CH_W'(g))),
         .i_pop      (q.i_pop  && (q.i_pop_ch  == CH_W'(g))),
         .i_flush    (q.i_flush[g]),
         .o_push_ok  (push_ok[g]),
         .o_pop_ok   (pop_ok[g]),
         .o_push_err (push_err[g]),
         .o_pop_err  (pop_err[g]),
         .o_wr_lo    (wr_lo[g]),
         .o_rd_lo    (rd_lo[g]),
         .o_full     (q.o_full_w[g]),
         .o_empty    (q.o_empty_w[g]),
         .o_afull    (q.o_afull_w[g])
      );
   end

   assign waddr = phys_addr(q.i_push_ch, wr_lo[q.i_push_ch]);
   assign raddr = phys_addr(q.i_pop_ch,  rd_lo[q.i_pop_ch]);

   rf #(.W(W), .N(N)) u_rf (
      .clk     (clk),
      .i_we    (|push_ok),
      .i_waddr (waddr),
      .i_wdata (q.i_push_dat),
      .i_raddr (raddr),
      .o_rdata (rdata)
   );

   always_comb begin
      pop_vld_d = |pop_ok;
      pop_ch_d  = pop_vld_d ? q.i_pop_ch : pop_ch_q;
      pop_dat_d = pop_vld_d ? rdata      : pop_dat_q;
      err_cause = ERR_NONE;
      if (|push_err)     err_cause = ERR_PUSH_FULL;
      else if (|pop_err) err_cause = ERR_POP_EMPTY;
      err_d = err_q || (err_cause != ERR_NONE);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pop_vld_q <= 1'b0;
         pop_ch_q  <= '0;
         pop_dat_q <= '0;
         err_q     <= 1'b0;
      end else begin
         pop_vld_q <= pop_vld_d;
         pop_ch_q  <= pop_ch_d;
         pop_dat_q <= pop_dat_d;
         err_q     <= err_d;
      end
   end

   assign q.o_pop_vld = pop_vld_q;
   assign q.o_pop_ch  = pop_ch_q;
   assign q.o_pop_dat = pop_dat_q;
   assign q.o_err     = err_q;
endmodule

// File: tb/tb_mqueue_rf.sv
// Directed bench for mqueue_rf with N=16, W=32, C=4, AF_THRESH=3.
module tb_mqueue_rf;
   logic clk;
   logic arst_n;
   int   errors;
   int   checks;

   mqueue_rf_if #(.W(32), .C(4)) q ();

   mqueue_rf #(.N(16), .W(32), .C(4), .AF_THRESH(3)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .q      (q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply one cycle of requests, let the edge happen, sample 1 time unit later.
   task automatic cyc(input logic pu, input logic [1:0] pch, input logic [31:0] pd,
                      input logic po, input logic [1:0] poc, input logic [3:0] fl);
      q.i_push = pu; q.i_push_ch = pch; q.i_push_dat = pd;
      q.i_pop = po;  q.i_pop_ch = poc;  q.i_flush = fl;
      @(posedge clk); #1;
      q.i_push = 1'b0; q.i_pop = 1'b0; q.i_flush = 4'h0;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      @(posedge clk); #1;
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      #2;
      checks++; if (q.o_empty_w !== 4'hF) begin errors++; $display("FAIL rst_empty got=%h exp=f", q.o_empty_w); end
      checks++; if (q.o_full_w !== 4'h0) begin errors++; $display("FAIL rst_full got=%h exp=0", q.o_full_w); end
      checks++; if (q.o_afull_w !== 4'h0) begin errors++; $display("FAIL rst_afull got=%h exp=0", q.o_afull_w); end
      checks++; if (q.o_pop_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b exp=0", q.o_pop_vld); end
      checks++; if (q.o_pop_ch !== 2'd0) begin errors++; $display("FAIL rst_ch got=%0d exp=0", q.o_pop_ch); end
      checks++; if (q.o_pop_dat !== 32'h0) begin errors++; $display("FAIL rst_dat got=%h exp=0", q.o_pop_dat); end
      checks++; if (q.o_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", q.o_err); end
      @(posedge clk); #1;
      arst_n = 1'b1;
   endtask

   task automatic test_fill_reject_drain();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 2'd2, 32'hA0 + i, 1'b0, 2'd0, 4'h0);
         checks++; if (q.o_afull_w[2] !== (i >= 2)) begin errors++; $display("FAIL fill_afull%0d got=%b exp=%b", i, q.o_afull_w[2], (i >= 2)); end
         checks++; if (q.o_full_w[2] !== (i == 3)) begin errors++; $display("FAIL fill_full%0d got=%b exp=%b", i, q.o_full_w[2], (i == 3)); end
      end
      checks++; if (q.o_err !== 1'b0) begin errors++; $display("FAIL fill_err got=%b exp=0", q.o_err); end
      cyc(1'b1, 2'd2, 32'hA4, 1'b0, 2'd0, 4'h0);
      checks++; if (q.o_err !== 1'b1) begin errors++; $display("FAIL rej_err got=%b exp=1", q.o_err); end
      checks++; if (q.o_full_w !== 4'h4) begin errors++; $display("FAIL rej_full got=%h exp=4", q.o_full_w); end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 4'h0);
         checks++; if (q.o_pop_vld !== 1'b1) begin errors++; $display("FAIL drain_vld%0d got=%b exp=1", i, q.o_pop_vld); end
         checks++; if (q.o_pop_ch !== 2'd2) begin errors++; $display("FAIL drain_ch%0d got=%0d exp=2", i, q.o_pop_ch); end
         checks++; if (q.o_pop_dat !== 32'hA0 + i) begin errors++; $display("FAIL drain_dat%0d got=%h exp=%h", i, q.o_pop_dat, 32'hA0 + i); end
      end
      checks++; if (q.o_empty_w !== 4'hF) begin errors++; $display("FAIL drain_empty got=%h exp=f", q.o_empty_w); end
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 4'h0);
      checks++; if (q.o_pop_vld !== 1'b0) begin errors++; $display("FAIL drain_extra_vld got=%b exp=0", q.o_pop_vld); end
      checks++; if (q.o_pop_dat !== 32'hA3) begin errors++; $display("FAIL drain_hold got=%h exp=a3", q.o_pop_dat); end
   endtask

   task automatic test_isolation();
      logic [1:0]  pch [3];
      logic [31:0] exp [3];
      pch[0] = 2'd3; pch[1] = 2'd0; pch[2] = 2'd0;
      exp[0] = 32'h30; exp[1] = 32'h10; exp[2] = 32'h11;
      do_reset();
      cyc(1'b1, 2'd0, 32'h10, 1'b0, 2'd0, 4'h0);
      cyc(1'b1, 2'd3, 32'h30, 1'b0, 2'd0, 4'h0);
      cyc(1'b1, 2'd0, 32'h11, 1'b0, 2'd0, 4'h0);
      checks++; if (q.o_empty_w !== 4'h6) begin errors++; $display("FAIL iso_empty got=%h exp=6", q.o_empty_w); end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 2'd0, 32'h0, 1'b1, pch[i], 4'h0);
         checks++; if (q.o_pop_vld !== 1'b1 || q.o_pop_ch !== pch[i] || q.o_pop_dat !== exp[i]) begin
            errors++; $display("FAIL iso_pop%0d got=%b/%0d/%h exp=1/%0d/%h", i, q.o_pop_vld, q.o_pop_ch, q.o_pop_dat, pch[i], exp[i]);
         end
      end
      checks++; if (q.o_err !== 1'b0) begin errors++; $display("FAIL iso_err got=%b exp=0", q.o_err); end
   endtask

   task automatic test_empty_push_pop();
      do_reset();
      cyc(1'b1, 2'd1, 32'h55, 1'b1, 2'd1, 4'h0);
      checks++; if (q.o_pop_vld !== 1'b0) begin errors++; $display("FAIL epp_vld got=%b exp=0", q.o_pop_vld); end
      checks++; if (q.o_err !== 1'b1) begin errors++; $display("FAIL epp_err got=%b exp=1", q.o_err); end
      checks++; if (q.o_empty_w[1] !== 1'b0) begin errors++; $display("FAIL epp_empty got=%b exp=0", q.o_empty_w[1]); end
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 4'h0);
      checks++; if (q.o_pop_vld !== 1'b1 || q.o_pop_dat !== 32'h55 || q.o_pop_ch !== 2'd1) begin
         errors++; $display("FAIL epp_pop got=%b/%0d/%h exp=1/1/55", q.o_pop_vld, q.o_pop_ch, q.o_pop_dat);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'd3, 32'hD0 + i, 1'b0, 2'd0, 4'h0);
      cyc(1'b1, 2'd3, 32'hD4, 1'b1, 2'd3, 4'h0);
      checks++; if (q.o_pop_vld !== 1'b1 || q.o_pop_dat !== 32'hD0) begin errors++; $display("FAIL fpp_pop got=%b/%h exp=1/d0", q.o_pop_vld, q.o_pop_dat); end
      checks++; if (q.o_err !== 1'b1) begin errors++; $display("FAIL fpp_err got=%b exp=1", q.o_err); end
      checks++; if (q.o_full_w[3] !== 1'b0) begin errors++; $display("FAIL fpp_full got=%b exp=0", q.o_full_w[3]); end
   endtask

   task automatic test_flush();
      do_reset();
      cyc(1'b1, 2'd0, 32'h01, 1'b0, 2'd0, 4'h0);
      cyc(1'b1, 2'd0, 32'h02, 1'b0, 2'd0, 4'h0);
      cyc(1'b1, 2'd3, 32'h33, 1'b0, 2'd0, 4'h0);
      cyc(1'b1, 2'd0, 32'h77, 1'b0, 2'd0, 4'h1);
      checks++; if (q.o_empty_w !== 4'h7) begin errors++; $display("FAIL fl_empty got=%h exp=7", q.o_empty_w); end
      checks++; if (q.o_err !== 1'b0) begin errors++; $display("FAIL fl_err got=%b exp=0", q.o_err); end
      cyc(1'b1, 2'd0, 32'h88, 1'b0, 2'd0, 4'h0);
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 4'h1);
      checks++; if (q.o_pop_vld !== 1'b0 || q.o_err !== 1'b0) begin errors++; $display("FAIL fl_pop got=%b/%b exp=0/0", q.o_pop_vld, q.o_err); end
      cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd3, 4'h0);
      checks++; if (q.o_pop_vld !== 1'b1 || q.o_pop_dat !== 32'h33) begin errors++; $display("FAIL fl_other got=%b/%h exp=1/33", q.o_pop_vld, q.o_pop_dat); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      cyc(1'b1, 2'd1, 32'hB0, 1'b0, 2'd0, 4'h0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 2'd1, 32'hB1 + i, 1'b1, 2'd1, 4'h0);
         checks++; if (q.o_pop_vld !== 1'b1 || q.o_pop_dat !== 32'hB0 + i) begin
            errors++; $display("FAIL wrap%0d got=%b/%h exp=1/%h", i, q.o_pop_vld, q.o_pop_dat, 32'hB0 + i);
         end
      end
      cyc(1'b1, 2'd2, 32'hC2, 1'b1, 2'd1, 4'h0);
      checks++; if (q.o_pop_vld !== 1'b1 || q.o_pop_dat !== 32'hBA || q.o_empty_w !== 4'hB) begin
         errors++; $display("FAIL wrap_last got=%b/%h/%h exp=1/ba/b", q.o_pop_vld, q.o_pop_dat, q.o_empty_w);
      end
      #2 arst_n = 1'b0;
      #1;
      checks++; if (q.o_pop_vld !== 1'b0 || q.o_pop_dat !== 32'h0 || q.o_pop_ch !== 2'd0) begin
         errors++; $display("FAIL mid_rst_pop got=%b/%h/%0d exp=0/0/0", q.o_pop_vld, q.o_pop_dat, q.o_pop_ch);
      end
      checks++; if (q.o_empty_w !== 4'hF || q.o_full_w !== 4'h0 || q.o_afull_w !== 4'h0 || q.o_err !== 1'b0) begin
         errors++; $display("FAIL mid_rst_stat got=%h/%h/%h/%b exp=f/0/0/0", q.o_empty_w, q.o_full_w, q.o_afull_w, q.o_err);
      end
      @(posedge clk); #1;
      arst_n = 1'b1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      q.i_push = 1'b0; q.i_push_ch = 2'd0; q.i_push_dat = 32'h0;
      q.i_pop = 1'b0;  q.i_pop_ch = 2'd0;  q.i_flush = 4'h0;
      test_reset();
      test_fill_reject_drain();
      test_isolation();
      test_empty_push_pop();
      test_full_push_pop();
      test_flush();
      test_wrap_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
